// File: rtl/ddp_bridge_pkg.sv
// Shared definitions for the DDP clocked-to-self-timed bridges (source and sink).
package ddp_bridge_pkg;

  localparam int DDP_DATA_W      = 32;
  localparam int DDP_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    REQ,
    REL
  } src_state_t;

endpackage

// File: rtl/ddp_sync_fifo.sv
// Single-clock FIFO with occupancy count; pointers wrap modulo DEPTH (power of two).
module ddp_sync_fifo
  import ddp_bridge_pkg::*;
#(
  parameter  int DATA_W = DDP_DATA_W,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign wr_en   = push && !full;
  assign rd_en   = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: storage has no reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ddp_src_bridge.sv
// Source bridge: buffers host words and hands each to the self-timed DDP pipeline
// head over a four-phase Send/Ack handshake with a synchronized acknowledge.
module ddp_src_bridge
  import ddp_bridge_pkg::*;
#(
  parameter  int DATA_W      = DDP_DATA_W,
  parameter  int DEPTH       = 4,
  parameter  int SYNC_STAGES = DDP_SYNC_STAGES,
  parameter  int SETUP_CYC   = 1,
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              MR,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] data_out,
  output logic              Send_out,
  input  logic              Ack_in,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              proto_err
);

  localparam int SC_W = $clog2(SETUP_CYC + 1);

  src_state_t             state, state_nxt;
  logic [SC_W-1:0]        setup_cnt, setup_cnt_nxt;
  logic                   send_nxt;
  logic                   pop;
  logic                   push;
  logic [DATA_W-1:0]      fifo_rd_data;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign busy     = (state != IDLE) || !fifo_empty;
  assign ack_s    = ack_sync[SYNC_STAGES-1];

  ddp_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (MR),
    .push    (push),
    .wr_data (in_data),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the chain shifts one stage per edge.
  always_ff @(posedge CLK) begin
    if (MR) ack_sync <= '0;
    else    ack_sync <= {ack_sync[SYNC_STAGES-2:0], Ack_in};
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    setup_cnt_nxt = setup_cnt;
    send_nxt      = Send_out;
    pop           = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop           = 1'b1;
          setup_cnt_nxt = SC_W'(SETUP_CYC);
          state_nxt     = SETUP;
        end
      end
      SETUP: begin
        // A counter of 1 decrements to 0 on this edge, which ends the setup window.
        if (setup_cnt <= SC_W'(1)) begin
          setup_cnt_nxt = '0;
          send_nxt      = 1'b1;
          state_nxt     = REQ;
        end else begin
          setup_cnt_nxt = setup_cnt - 1'b1;
        end
      end
      REQ: begin
        if (ack_s) begin
          send_nxt  = 1'b0;
          state_nxt = REL;
        end
      end
      REL: begin
        if (!ack_s) begin
          if (!fifo_empty) begin
            pop           = 1'b1;
            setup_cnt_nxt = SC_W'(SETUP_CYC);
            state_nxt     = SETUP;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (MR) begin
      state     <= IDLE;
      setup_cnt <= '0;
      Send_out  <= 1'b0;
      data_out  <= '0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      setup_cnt <= setup_cnt_nxt;
      Send_out  <= send_nxt;
      if (pop) data_out <= fifo_rd_data;
      // An acknowledge before any request was raised means the pipeline misbehaved.
      if (ack_s && (state == IDLE || state == SETUP)) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddp_src_bridge.sv
// Directed bench for ddp_src_bridge: a scoreboard queue of pushed words is checked
// against data_out on every Send_out rise, alongside directed timing checks.
module tb_ddp_src_bridge;
  import ddp_bridge_pkg::*;

  localparam int DW = DDP_DATA_W;

  logic          CLK = 1'b0;
  logic          MR = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] data_out;
  logic          Send_out;
  logic          Ack_in;
  logic [2:0]    count;
  logic          busy;
  logic          proto_err;

  logic          resp_en = 1'b0;
  logic          resp_ack = 1'b0;
  logic          pulse_ack = 1'b0;
  int            dly = 0;

  logic [31:0]   exp_q[$];
  int            errors = 0;
  int            checks = 0;
  int            n_sends = 0;
  logic          prev_send = 1'b0;

  assign Ack_in = resp_ack | pulse_ack;

  always #5 CLK = ~CLK;

  ddp_src_bridge #(
    .DATA_W      (DW),
    .DEPTH       (4),
    .SYNC_STAGES (DDP_SYNC_STAGES),
    .SETUP_CYC   (1)
  ) dut (
    .CLK       (CLK),
    .MR        (MR),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .data_out  (data_out),
    .Send_out  (Send_out),
    .Ack_in    (Ack_in),
    .count     (count),
    .busy      (busy),
    .proto_err (proto_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pipeline-stage responder: mirrors Send_out onto Ack a few cycles later.
  always @(negedge CLK) begin
    if (MR) begin
      resp_ack = 1'b0;
      dly      = 0;
    end else if (Send_out != resp_ack) begin
      if (Send_out && !resp_en) begin
        dly = 0;
      end else begin
        dly++;
        if (dly == 3) begin
          resp_ack = Send_out;
          dly      = 0;
        end
      end
    end else begin
      dly = 0;
    end
  end

  // Monitor: every new request must present the oldest outstanding word.
  always @(negedge CLK) begin
    if (MR) begin
      prev_send = 1'b0;
    end else begin
      if (Send_out && !prev_send) begin
        n_sends++;
        check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("send_data", data_out, exp_q.pop_front());
      end
      prev_send = Send_out;
    end
  end

  task automatic do_reset();
    MR = 1'b1;
    repeat (3) @(negedge CLK);
    MR = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_word(input logic [31:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      check("push_timeout", 32'(in_ready), 32'd1);
    end else begin
      exp_q.push_back(d);
      @(negedge CLK);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while ((busy || Ack_in || Send_out) && n < 500);
    check(name, 32'(busy | Ack_in | Send_out), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   s0;
    int   n;
    logic any_send;
    logic held_bad;

    // Reset state and quiet idle behaviour.
    do_reset();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_send", 32'(Send_out), 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);
    any_send = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      if (Send_out) any_send = 1'b1;
    end
    check("idle_no_send", 32'(any_send), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Single word: data one cycle after push, Send the cycle after that.
    resp_en = 1'b1;
    s0 = n_sends;
    push_word(32'hDEADBEEF);
    check("single_count", 32'(count), 32'd1);
    check("single_data_pre", data_out, 32'd0);
    @(negedge CLK);
    check("single_data_out", data_out, 32'hDEADBEEF);
    check("single_send_low", 32'(Send_out), 32'd0);
    @(negedge CLK);
    check("single_send_high", 32'(Send_out), 32'd1);
    wait_idle("single_idle");
    check("single_one_cycle", 32'(n_sends - s0), 32'd1);
    check("single_no_proto_err", 32'(proto_err), 32'd0);

    // Stalled responder: fill to full, sixth word waits for the first handshake.
    resp_en = 1'b0;
    s0 = n_sends;
    for (int i = 1; i <= 5; i++) push_word(32'(i));
    check("stall_count_full", 32'(count), 32'd4);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 32'h6;
    held_bad = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      if (in_ready || count != 3'd4) held_bad = 1'b1;
    end
    check("stall_held_off", 32'(held_bad), 32'd0);
    check("stall_one_send", 32'(n_sends - s0), 32'd1);
    resp_en = 1'b1;
    push_word(32'h6);
    wait_idle("stall_idle");
    check("stall_sends", 32'(n_sends - s0), 32'd6);

    // Push lands on the same edge as the REL pop, with two words queued.
    resp_en = 1'b0;
    push_word(32'h10);
    push_word(32'h11);
    push_word(32'h12);
    check("pp_count_pre", 32'(count), 32'd2);
    resp_en = 1'b1;
    n = 0;
    do begin @(negedge CLK); #1; n++; end while (!Ack_in && n < 50);
    do begin @(negedge CLK); #1; n++; end while (Ack_in && n < 100);
    check("pp_ack_seen", 32'(Ack_in), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    check("pp_count_before", 32'(count), 32'd2);
    check("pp_data_before", data_out, 32'h10);
    in_valid = 1'b1;
    in_data  = 32'h13;
    exp_q.push_back(32'h13);
    @(negedge CLK);
    in_valid = 1'b0;
    check("pp_count_after", 32'(count), 32'd2);
    check("pp_data_after", data_out, 32'h11);
    wait_idle("pp_idle");

    // Continuous stream: pointers wrap repeatedly.
    s0 = n_sends;
    for (int i = 0; i < 20; i++) push_word(32'h100 + 32'(i));
    wait_idle("stream_idle");
    check("stream_sends", 32'(n_sends - s0), 32'd20);
    check("stream_sb_empty", 32'(exp_q.size()), 32'd0);

    // Master reset in the middle of a request.
    resp_en = 1'b0;
    push_word(32'hA5);
    n = 0;
    while (!Send_out && n < 20) begin @(negedge CLK); n++; end
    check("mr_in_req", 32'(Send_out), 32'd1);
    check("mr_data_a5", data_out, 32'hA5);
    MR = 1'b1;
    @(negedge CLK);
    MR = 1'b0;
    exp_q.delete();
    check("mr_send", 32'(Send_out), 32'd0);
    check("mr_count", 32'(count), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_data_out", data_out, 32'd0);
    any_send = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      if (Send_out) any_send = 1'b1;
    end
    check("mr_no_send", 32'(any_send), 32'd0);

    // Spurious acknowledge while idle.
    pulse_ack = 1'b1;
    @(negedge CLK);
    pulse_ack = 1'b0;
    n = 0;
    while (!proto_err && n < 3) begin @(negedge CLK); n++; end
    check("perr_set", 32'(proto_err), 32'd1);
    repeat (5) @(negedge CLK);
    check("perr_sticky", 32'(proto_err), 32'd1);
    resp_en = 1'b1;
    s0 = n_sends;
    push_word(32'h5A5A);
    wait_idle("perr_xfer_idle");
    check("perr_xfer_sends", 32'(n_sends - s0), 32'd1);
    check("perr_still_set", 32'(proto_err), 32'd1);
    do_reset();
    check("perr_cleared", 32'(proto_err), 32'd0);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
